alu_arbiter: RTL

//  Shares the single combinational 16-bit ALU between two requesters:

---
 rtl/alu_pkg.sv | 22 ++
 rtl/rr_arbiter2.sv | 15 +
 rtl/alu_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: ALU opcodes and controller state encoding.
package alu_pkg;

  // ALU opcodes; 3'b111 is unassigned and the ALU returns zero for it.
  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpShl = 3'b010;
  localparam logic [2:0] OpAsh = 3'b011;
  localparam logic [2:0] OpAnd = 3'b100;
  localparam logic [2:0] OpOr  = 3'b101;
  localparam logic [2:0] OpXor = 3'b110;

  // Exec counter width; EXEC_CYCLES is limited to 1..15.
  localparam int unsigned CntW = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin pick; the pointer register lives in the parent.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       any,
  output logic       winner
);

  // Both requesting -> pointer port wins; otherwise the single requester wins.
  always_comb begin
    any    = |req;
    winner = (&req) ? ptr : req[1];
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters with round-robin grants,
// holds the ALU inputs for EXEC_CYCLES cycles and returns registered result/flags.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned OPW         = 3,
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic             input_CLK,
  input  logic             input_Reset,
  input  logic             input_Req0,
  input  logic             input_Req1,
  input  logic [WIDTH-1:0] input_A0,
  input  logic [WIDTH-1:0] input_A1,
  input  logic [WIDTH-1:0] input_B0,
  input  logic [WIDTH-1:0] input_B1,
  input  logic [OPW-1:0]   input_ALUOp0,
  input  logic [OPW-1:0]   input_ALUOp1,
  output logic             output_Gnt0,
  output logic             output_Gnt1,
  output logic             output_Valid0,
  output logic             output_Valid1,
  output logic [WIDTH-1:0] output_Result,
  output logic             output_Zero,
  output logic             output_negative,
  output logic [WIDTH-1:0] output_ALU_A,
  output logic [WIDTH-1:0] output_ALU_B,
  output logic [OPW-1:0]   output_ALUOp,
  input  logic [WIDTH-1:0] input_ALU_Result,
  input  logic             input_ALU_Zero,
  input  logic             input_ALU_Negative
);

  localparam logic [CntW-1:0] LastCnt = CntW'(EXEC_CYCLES - 1);

  arb_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q;
  logic            ptr_q, owner_q;
  logic [WIDTH-1:0] a_q, b_q, result_q;
  logic [OPW-1:0]  op_q;
  logic            zero_q, neg_q;
  logic            gnt0_q, gnt1_q, valid0_q, valid1_q;
  logic            req_any, winner, exec_last;

  rr_arbiter2 u_rr (
    .req    ({input_Req1, input_Req0}),
    .ptr    (ptr_q),
    .any    (req_any),
    .winner (winner)
  );

  // State register.
  always_ff @(posedge input_CLK or posedge input_Reset) begin
    if (input_Reset) state_q <= StIdle;
    else             state_q <= state_d;
  end

  // Next-state: grant from idle, hold exec for EXEC_CYCLES, one response cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (req_any) state_d = StExec;
      StExec:  if (exec_last) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs of the FSM: exec-done strobe and ALU drive, zero outside exec.
  always_comb begin
    exec_last    = (state_q == StExec) && (cnt_q == LastCnt);
    output_ALU_A = '0;
    output_ALU_B = '0;
    output_ALUOp = '0;
    if (state_q == StExec) begin
      output_ALU_A = a_q;
      output_ALU_B = b_q;
      output_ALUOp = op_q;
    end
  end

  // Datapath: operand latch, exec counter, result capture, pulses and pointer.
  always_ff @(posedge input_CLK or posedge input_Reset) begin
    if (input_Reset) begin
      cnt_q    <= '0;
      ptr_q    <= 1'b0;
      owner_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      valid0_q <= 1'b0;
      valid1_q <= 1'b0;
    end else begin
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      valid0_q <= 1'b0;
      valid1_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req_any) begin
            owner_q <= winner;
            a_q     <= winner ? input_A1 : input_A0;
            b_q     <= winner ? input_B1 : input_B0;
            op_q    <= winner ? input_ALUOp1 : input_ALUOp0;
            gnt0_q  <= ~winner;
            gnt1_q  <= winner;
            cnt_q   <= '0;
          end
        end
        StExec: begin
          if (exec_last) begin
            result_q <= input_ALU_Result;
            zero_q   <= input_ALU_Zero;
            neg_q    <= input_ALU_Negative;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StResp: begin
          valid0_q <= ~owner_q;
          valid1_q <= owner_q;
          ptr_q    <= ~owner_q;
        end
        default: ;
      endcase
    end
  end

  assign output_Gnt0     = gnt0_q;
  assign output_Gnt1     = gnt1_q;
  assign output_Valid0   = valid0_q;
  assign output_Valid1   = valid1_q;
  assign output_Result   = result_q;
  assign output_Zero     = zero_q;
  assign output_negative = neg_q;

endmodule
